capture_sequencer: RTL and testbench

- Capture-control FSM that sequences the sample packet generator through one capture: idle, start, pre-trigger fill, armed, post-trigger, done/abort.
- Produces the phase strobes (idle, preTrigger, postTrigger, triggered, start, abort) that the generator consumes.
- Qualifies the external trigger so it is only accepted once the pre-trigger window has filled.
- Sits between the host command/register block and the sample generator; reports status back to the host.

---
 rtl/capture_sequencer.sv | 172 +++++++++++++++++
 tb/tb_capture_sequencer.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/capture_sequencer.sv
// Capture-control FSM: IDLE -> START -> PRE_FILL -> ARMED -> POST -> DONE, with ABORT from any running phase.
// Latency: cmd_arm -> start +1 cycle, trig_in -> triggered +1 cycle -> postTrigger +2 cycles; outputs decoded from registers.
// No backpressure: single-cycle strobes in, level/pulse strobes out. Optional auto-trigger timeout under `CAPTURE_SEQ_TIMEOUT_EN.
module capture_sequencer #(
  parameter int COUNT_WIDTH = 32,
  parameter int STATE_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   cmd_arm,
  input  logic                   cmd_abort,
  input  logic                   trig_in,
  input  logic                   sample_we,
  input  logic                   capture_complete,
  input  logic [COUNT_WIDTH-1:0] preTriggerSampleCountMax,
  input  logic [COUNT_WIDTH-1:0] timeout_cycles,
  output logic                   idle,
  output logic                   start,
  output logic                   preTrigger,
  output logic                   postTrigger,
  output logic                   triggered,
  output logic                   abort,
  output logic                   done,
  output logic                   busy,
  output logic [STATE_WIDTH-1:0] state,
  output logic                   forced_trig
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_START    = 3'd1,
    S_PRE_FILL = 3'd2,
    S_ARMED    = 3'd3,
    S_POST     = 3'd4,
    S_DONE     = 3'd5,
    S_ABORT    = 3'd6
  } state_t;

  state_t                 cur_st, nxt_st;
  logic [COUNT_WIDTH-1:0] fill_cnt, fill_nxt, fill_inc;
  logic [COUNT_WIDTH-1:0] max_hold, max_nxt;
  // trig_pend holds ARMED for one extra cycle so triggered overlaps the last preTrigger cycle
  logic                   trig_pend, trig_pend_nxt;
  // Remember which phase an abort came from so that phase strobe stays high during ABORT
  logic                   from_pre, from_pre_nxt;
  logic                   from_post, from_post_nxt;
  logic                   forced_q, forced_nxt;
  logic                   tmo_hit;

  // Saturating fill count including this cycle's write
  assign fill_inc = (sample_we && (fill_cnt != '1)) ? fill_cnt + COUNT_WIDTH'(1) : fill_cnt;

`ifdef CAPTURE_SEQ_TIMEOUT_EN
  logic [COUNT_WIDTH-1:0] tmo_cnt, tmo_nxt;

  assign tmo_hit = (timeout_cycles != '0) && (tmo_cnt == timeout_cycles - COUNT_WIDTH'(1));

  // Timeout counter advances only in ARMED and is zero on every ARMED entry
  always_comb begin
    tmo_nxt = '0;
    if (cur_st == S_ARMED) begin
      tmo_nxt = (tmo_cnt == '1) ? tmo_cnt : tmo_cnt + COUNT_WIDTH'(1);
    end
  end

  // Timeout counter register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
    end else begin
      tmo_cnt <= tmo_nxt;
    end
  end
`else
  logic unused_timeout;

  assign tmo_hit        = 1'b0;
  assign unused_timeout = ^timeout_cycles;
`endif

  // Next-state and next-context logic; abort beats trigger, completion beats abort
  always_comb begin
    nxt_st        = cur_st;
    fill_nxt      = fill_cnt;
    max_nxt       = max_hold;
    trig_pend_nxt = 1'b0;
    from_pre_nxt  = 1'b0;
    from_post_nxt = 1'b0;
    forced_nxt    = forced_q;
    case (cur_st)
      S_IDLE: begin
        fill_nxt   = '0;
        forced_nxt = 1'b0;
        if (cmd_arm) nxt_st = S_START;
      end
      S_START: begin
        max_nxt    = preTriggerSampleCountMax;
        forced_nxt = 1'b0;
        if (cmd_abort) nxt_st = S_ABORT;
        else if (preTriggerSampleCountMax == '0) nxt_st = S_ARMED;
        else nxt_st = S_PRE_FILL;
      end
      S_PRE_FILL: begin
        if (cmd_abort) begin
          nxt_st       = S_ABORT;
          from_pre_nxt = 1'b1;
        end else begin
          fill_nxt = fill_inc;
          if (fill_inc >= max_hold) nxt_st = S_ARMED;
        end
      end
      S_ARMED: begin
        if (cmd_abort) begin
          nxt_st       = S_ABORT;
          from_pre_nxt = 1'b1;
        end else if (trig_pend) begin
          nxt_st = S_POST;
        end else if (trig_in) begin
          trig_pend_nxt = 1'b1;
        end else if (tmo_hit) begin
          trig_pend_nxt = 1'b1;
          forced_nxt    = 1'b1;
        end
      end
      S_POST: begin
        if (capture_complete) begin
          nxt_st = S_DONE;
        end else if (cmd_abort) begin
          nxt_st        = S_ABORT;
          from_post_nxt = 1'b1;
        end
      end
      S_DONE:  nxt_st = S_IDLE;
      S_ABORT: nxt_st = S_IDLE;
      default: nxt_st = S_IDLE;
    endcase
  end

  // State and capture-context registers; reset drops straight to IDLE without pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_st    <= S_IDLE;
      fill_cnt  <= '0;
      max_hold  <= '0;
      trig_pend <= 1'b0;
      from_pre  <= 1'b0;
      from_post <= 1'b0;
      forced_q  <= 1'b0;
    end else begin
      cur_st    <= nxt_st;
      fill_cnt  <= fill_nxt;
      max_hold  <= max_nxt;
      trig_pend <= trig_pend_nxt;
      from_pre  <= from_pre_nxt;
      from_post <= from_post_nxt;
      forced_q  <= forced_nxt;
    end
  end

  // Moore output decode from registered state and flags
  assign idle        = (cur_st == S_IDLE);
  assign start       = (cur_st == S_START);
  assign preTrigger  = (cur_st == S_PRE_FILL) || (cur_st == S_ARMED) || ((cur_st == S_ABORT) && from_pre);
  assign postTrigger = (cur_st == S_POST) || ((cur_st == S_ABORT) && from_post);
  assign triggered   = trig_pend;
  assign abort       = (cur_st == S_ABORT);
  assign done        = (cur_st == S_DONE);
  assign busy        = (cur_st != S_IDLE);
  assign state       = STATE_WIDTH'(cur_st);
  assign forced_trig = forced_q;

endmodule

// File: tb/tb_capture_sequencer.sv
module tb_capture_sequencer;

  localparam int CW = 32;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_arm, cmd_abort, trig_in, sample_we, capture_complete;
  logic [CW-1:0] preTriggerSampleCountMax, timeout_cycles;
  logic          idle, start, preTrigger, postTrigger, triggered, abort, done, busy, forced_trig;
  logic [SW-1:0] state;

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    bit arm; bit abt; bit tin; bit we; bit cc;
    int st;  bit trg; int ph;  bit frc;
  } step_t;

  step_t       plan[$];
  logic [11:0] sb[$];

  capture_sequencer #(.COUNT_WIDTH(CW), .STATE_WIDTH(SW)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_arm(cmd_arm), .cmd_abort(cmd_abort), .trig_in(trig_in),
    .sample_we(sample_we), .capture_complete(capture_complete),
    .preTriggerSampleCountMax(preTriggerSampleCountMax), .timeout_cycles(timeout_cycles),
    .idle(idle), .start(start), .preTrigger(preTrigger), .postTrigger(postTrigger),
    .triggered(triggered), .abort(abort), .done(done), .busy(busy),
    .state(state), .forced_trig(forced_trig)
  );

  always #5 clk = ~clk;

  // Expected output vector for a given state; ph: 1 = abort from pre-trigger, 2 = from post-trigger
  function automatic logic [11:0] expv(input int st, input bit trg, input int ph, input bit frc);
    return {st == 0, st == 1, (st == 2) || (st == 3) || (st == 6 && ph == 1),
            (st == 4) || (st == 6 && ph == 2), trg, st == 6, st == 5, st != 0, frc, 3'(st)};
  endfunction

  function automatic logic [11:0] obs();
    return {idle, start, preTrigger, postTrigger, triggered, abort, done, busy, forced_trig, state};
  endfunction

  // One plan step: inputs for a cycle and the outputs expected just after that edge
  function automatic void add(input bit arm, input bit abt, input bit tin, input bit we, input bit cc,
                              input int st, input bit trg = 1'b0, input int ph = 0, input bit frc = 1'b0);
    step_t s;
    s.arm = arm; s.abt = abt; s.tin = tin; s.we = we; s.cc = cc;
    s.st = st; s.trg = trg; s.ph = ph; s.frc = frc;
    plan.push_back(s);
  endfunction

  task automatic drive_zero();
    cmd_arm = 0; cmd_abort = 0; trig_in = 0; sample_we = 0; capture_complete = 0;
  endtask

  task automatic test_reset();
    logic [11:0] want, got;
    sb.push_back(expv(0, 0, 0, 0));
    want = sb.pop_front(); got = obs(); n_chk++;
    if (got !== want) $display("FAIL reset_state: got %b want %b", got, want);
    else n_pass++;
  endtask

  task automatic test_normal();
    step_t s; logic [11:0] want, got; int k;
    k = 0;
    preTriggerSampleCountMax = 4;
    add(1,0,0,0,0, 1);
    add(0,0,0,0,0, 2);
    add(0,0,0,1,0, 2); add(0,0,0,1,0, 2); add(0,0,0,1,0, 2);
    add(0,0,0,1,0, 3);
    add(0,0,0,0,0, 3);
    add(0,0,1,0,0, 3, 1);
    add(0,0,0,0,0, 4);
    add(0,0,0,1,0, 4);
    add(0,0,0,0,1, 5);
    add(0,0,0,0,0, 0);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      cmd_arm = s.arm; cmd_abort = s.abt; trig_in = s.tin; sample_we = s.we; capture_complete = s.cc;
      sb.push_back(expv(s.st, s.trg, s.ph, s.frc));
      @(posedge clk); #1;
      want = sb.pop_front(); got = obs(); n_chk++; k++;
      if (got !== want) $display("FAIL normal step %0d: got %b want %b", k, got, want);
      else n_pass++;
    end
    drive_zero();
  endtask

  task automatic test_early_trigger();
    step_t s; logic [11:0] want, got; int k;
    k = 0;
    preTriggerSampleCountMax = 8;
    add(1,0,0,0,0, 1);
    add(0,0,0,0,0, 2);
    for (int i = 0; i < 3; i++) add(0,0,0,1,0, 2);
    add(0,0,1,0,0, 2);
    for (int i = 0; i < 4; i++) add(0,0,0,1,0, 2);
    add(0,0,0,1,0, 3);
    add(0,0,1,0,0, 3, 1);
    add(0,0,0,0,0, 4);
    add(0,0,0,0,1, 5);
    add(0,0,0,0,0, 0);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      cmd_arm = s.arm; cmd_abort = s.abt; trig_in = s.tin; sample_we = s.we; capture_complete = s.cc;
      sb.push_back(expv(s.st, s.trg, s.ph, s.frc));
      @(posedge clk); #1;
      want = sb.pop_front(); got = obs(); n_chk++; k++;
      if (got !== want) $display("FAIL early_trigger step %0d: got %b want %b", k, got, want);
      else n_pass++;
    end
    drive_zero();
  endtask

  task automatic test_zero_pretrigger();
    step_t s; logic [11:0] want, got; int k;
    k = 0;
    preTriggerSampleCountMax = 0;
    add(1,0,0,0,0, 1);
    add(0,0,0,0,0, 3);
    add(0,0,1,0,0, 3, 1);
    add(0,0,0,0,0, 4);
    add(0,1,0,0,0, 6, 0, 2);
    add(0,0,0,0,0, 0);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      cmd_arm = s.arm; cmd_abort = s.abt; trig_in = s.tin; sample_we = s.we; capture_complete = s.cc;
      sb.push_back(expv(s.st, s.trg, s.ph, s.frc));
      @(posedge clk); #1;
      want = sb.pop_front(); got = obs(); n_chk++; k++;
      if (got !== want) $display("FAIL zero_pre_abort_post step %0d: got %b want %b", k, got, want);
      else n_pass++;
    end
    drive_zero();
  endtask

  task automatic test_abort_races();
    step_t s; logic [11:0] want, got; int k;
    k = 0;
    preTriggerSampleCountMax = 0;
    add(0,1,0,0,0, 0);
    add(1,0,0,0,0, 1);
    add(0,0,0,0,0, 3);
    add(0,1,1,0,0, 6, 0, 1);
    add(0,0,0,0,0, 0);
    add(1,0,0,0,0, 1);
    add(0,0,0,0,0, 3);
    add(0,0,1,0,0, 3, 1);
    add(0,0,0,0,0, 4);
    add(0,1,0,0,1, 5);
    add(0,1,0,0,0, 0);
    add(0,0,0,0,0, 0);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      cmd_arm = s.arm; cmd_abort = s.abt; trig_in = s.tin; sample_we = s.we; capture_complete = s.cc;
      sb.push_back(expv(s.st, s.trg, s.ph, s.frc));
      @(posedge clk); #1;
      want = sb.pop_front(); got = obs(); n_chk++; k++;
      if (got !== want) $display("FAIL abort_races step %0d: got %b want %b", k, got, want);
      else n_pass++;
    end
    drive_zero();
  endtask

  task automatic test_back_to_back();
    step_t s; logic [11:0] want, got; int k;
    k = 0;
    preTriggerSampleCountMax = 2;
    add(1,0,0,0,0, 1);
    add(1,0,0,0,0, 2);
    add(1,0,0,1,0, 2);
    add(1,0,0,1,0, 3);
    add(1,0,0,0,0, 3);
    add(1,0,1,0,0, 3, 1);
    add(1,0,0,0,0, 4);
    add(1,0,0,0,1, 5);
    add(1,0,0,0,0, 0);
    add(1,0,0,0,0, 1);
    add(0,0,0,0,0, 2);
    add(0,0,0,1,0, 2);
    add(0,1,0,0,0, 6, 0, 1);
    add(0,0,0,0,0, 0);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      cmd_arm = s.arm; cmd_abort = s.abt; trig_in = s.tin; sample_we = s.we; capture_complete = s.cc;
      sb.push_back(expv(s.st, s.trg, s.ph, s.frc));
      @(posedge clk); #1;
      want = sb.pop_front(); got = obs(); n_chk++; k++;
      if (got !== want) $display("FAIL back_to_back step %0d: got %b want %b", k, got, want);
      else n_pass++;
    end
    drive_zero();
  endtask

  task automatic test_reset_mid_capture();
    step_t s; logic [11:0] want, got; int k;
    k = 0;
    preTriggerSampleCountMax = 0;
    add(1,0,0,0,0, 1);
    add(0,0,0,0,0, 3);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      cmd_arm = s.arm; cmd_abort = s.abt; trig_in = s.tin; sample_we = s.we; capture_complete = s.cc;
      sb.push_back(expv(s.st, s.trg, s.ph, s.frc));
      @(posedge clk); #1;
      want = sb.pop_front(); got = obs(); n_chk++; k++;
      if (got !== want) $display("FAIL reset_mid step %0d: got %b want %b", k, got, want);
      else n_pass++;
    end
    drive_zero();
    #2 reset_n = 0;
    sb.push_back(expv(0, 0, 0, 0));
    #1;
    want = sb.pop_front(); got = obs(); n_chk++;
    if (got !== want) $display("FAIL reset_async: got %b want %b", got, want);
    else n_pass++;
    sb.push_back(expv(0, 0, 0, 0));
    @(posedge clk); #1;
    want = sb.pop_front(); got = obs(); n_chk++;
    if (got !== want) $display("FAIL reset_hold: got %b want %b", got, want);
    else n_pass++;
    reset_n = 1;
    sb.push_back(expv(0, 0, 0, 0));
    @(posedge clk); #1;
    want = sb.pop_front(); got = obs(); n_chk++;
    if (got !== want) $display("FAIL reset_release: got %b want %b", got, want);
    else n_pass++;
  endtask

  task automatic test_timeout();
    step_t s; logic [11:0] want, got; int k;
    k = 0;
    preTriggerSampleCountMax = 0;
    timeout_cycles = 10;
`ifdef CAPTURE_SEQ_TIMEOUT_EN
    add(1,0,0,0,0, 1);
    add(0,0,0,0,0, 3);
    for (int i = 0; i < 9; i++) add(0,0,0,0,0, 3);
    add(0,0,0,0,0, 3, 1, 0, 1);
    add(0,0,0,0,0, 4, 0, 0, 1);
    add(0,0,0,0,1, 5, 0, 0, 1);
    add(0,0,0,0,0, 0, 0, 0, 1);
    add(0,0,0,0,0, 0);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      cmd_arm = s.arm; cmd_abort = s.abt; trig_in = s.tin; sample_we = s.we; capture_complete = s.cc;
      sb.push_back(expv(s.st, s.trg, s.ph, s.frc));
      @(posedge clk); #1;
      want = sb.pop_front(); got = obs(); n_chk++; k++;
      if (got !== want) $display("FAIL timeout10 step %0d: got %b want %b", k, got, want);
      else n_pass++;
    end
    timeout_cycles = 0;
    add(1,0,0,0,0, 1);
    for (int i = 0; i < 20; i++) add(0,0,0,0,0, 3);
`else
    add(1,0,0,0,0, 1);
    for (int i = 0; i < 15; i++) add(0,0,0,0,0, 3);
`endif
    add(0,1,0,0,0, 6, 0, 1);
    add(0,0,0,0,0, 0);
    while (plan.size() > 0) begin
      s = plan.pop_front();
      cmd_arm = s.arm; cmd_abort = s.abt; trig_in = s.tin; sample_we = s.we; capture_complete = s.cc;
      sb.push_back(expv(s.st, s.trg, s.ph, s.frc));
      @(posedge clk); #1;
      want = sb.pop_front(); got = obs(); n_chk++; k++;
      if (got !== want) $display("FAIL no_timeout step %0d: got %b want %b", k, got, want);
      else n_pass++;
    end
    drive_zero();
    timeout_cycles = 0;
  endtask

  initial begin
    reset_n = 0;
    drive_zero();
    preTriggerSampleCountMax = 0;
    timeout_cycles = 0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    reset_n = 1;
    test_normal();
    test_early_trigger();
    test_zero_pretrigger();
    test_abort_races();
    test_back_to_back();
    test_reset_mid_capture();
    test_timeout();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
